// File: rtl/counter_pkg.sv
// Shared definitions for the up-counter and down-counter/timer blocks.
package counter_pkg;

    // Counter FSM encoding shared by both counter blocks.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam int DEFAULT_WIDTH = 4;

endpackage

// File: rtl/down_counter_timer_if.sv
// Control/status bundle of the down-counter/timer.
interface down_counter_timer_if
    import counter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             enable;
    logic             load;
    logic [WIDTH-1:0] load_value;
    logic             reload_mode;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             zero;
    logic             expired;

    // Controller side: drives the controls, observes the status.
    modport master (
        output enable, load, load_value, reload_mode,
        input  count, busy, zero, expired
    );

    // Timer side.
    modport slave (
        input  enable, load, load_value, reload_mode,
        output count, busy, zero, expired
    );
endinterface

// File: rtl/down_counter_timer_prescaler.sv
// Divides enabled cycles into count ticks: one tick every PRESCALE enabled cycles.
module prescaler #(
    parameter int PRESCALE = 1
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tick
);
    localparam int            PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] pcnt_q, pcnt_d;

    // Tick on the last phase; clear wins over enable and suppresses the tick.
    always_comb begin
        tick   = enable && !clear && (pcnt_q == LAST);
        pcnt_d = pcnt_q;
        if (clear)       pcnt_d = '0;
        else if (enable) pcnt_d = tick ? '0 : pcnt_q + PW'(1);
    end

    // Phase counter register.
    always_ff @(posedge clock) begin
        if (reset) pcnt_q <= '0;
        else       pcnt_q <= pcnt_d;
    end
endmodule

// File: rtl/down_counter_timer.sv
// Loadable down-counter/timer with prescaled ticks, one-shot or periodic reload.
module down_counter_timer
    import counter_pkg::*;
#(
    parameter int WIDTH    = DEFAULT_WIDTH,
    parameter int PRESCALE = 1
) (
    input logic                  clock,
    input logic                  reset,
    down_counter_timer_if.slave  bus
);
    state_e           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             expired_q, expired_d;
    logic             tick;
    logic             busy;

    assign busy = (state_q == ST_RUN);

    // Prescaler phase is held at 0 while idle and restarted by every load.
    prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
        .clock  (clock),
        .reset  (reset),
        .clear  (bus.load | ~busy),
        .enable (bus.enable),
        .tick   (tick)
    );

    // Next-state: load beats tick; a load on the terminal edge drops the pulse.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        reload_d  = reload_q;
        expired_d = 1'b0;
        if (bus.load) begin
            count_d  = bus.load_value;
            reload_d = bus.load_value;
            state_d  = (bus.load_value != '0) ? ST_RUN : ST_IDLE;
        end else if (busy && tick) begin
            if (count_q > WIDTH'(1)) begin
                count_d = count_q - WIDTH'(1);
            end else begin
                expired_d = 1'b1;
                if (bus.reload_mode) begin
                    count_d = reload_q;
                end else begin
                    count_d = '0;
                    state_d = ST_IDLE;
                end
            end
        end
    end

    // State, counter, reload value and registered expiry pulse.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            reload_q  <= '0;
            expired_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            reload_q  <= reload_d;
            expired_q <= expired_d;
        end
    end

    assign bus.count   = count_q;
    assign bus.busy    = busy;
    assign bus.zero    = (count_q == '0);
    assign bus.expired = expired_q;
endmodule

// File: tb/tb_down_counter_timer.sv
// Scoreboard bench: two timers (PRESCALE=1 and PRESCALE=4) driven cycle by cycle.
module tb_down_counter_timer;
    typedef struct {
        logic [3:0] cnt;
        logic       busy;
        logic       exp;
        logic       zero;
    } exp_t;

    logic clock;
    logic reset;
    int   checks;
    int   errors;
    exp_t sbq[$];

    down_counter_timer_if #(.WIDTH(4)) b1 ();
    down_counter_timer_if #(.WIDTH(4)) b4 ();

    down_counter_timer #(.WIDTH(4), .PRESCALE(1)) u_p1 (.clock(clock), .reset(reset), .bus(b1));
    down_counter_timer #(.WIDTH(4), .PRESCALE(4)) u_p4 (.clock(clock), .reset(reset), .bus(b4));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic exp_t mk(input int c, input logic b, input logic e);
        exp_t r;
        r.cnt  = 4'(c);
        r.busy = b;
        r.exp  = e;
        r.zero = (c == 0);
        return r;
    endfunction

    task automatic test_reset();
        checks++;
        if ({b1.count, b1.busy, b1.expired, b1.zero} !== {4'd0, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset_p1: got count=%0d busy=%0b expired=%0b zero=%0b, want 0/0/0/1",
                     b1.count, b1.busy, b1.expired, b1.zero);
        end
        checks++;
        if ({b4.count, b4.busy, b4.expired, b4.zero} !== {4'd0, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset_p4: got count=%0d busy=%0b expired=%0b zero=%0b, want 0/0/0/1",
                     b4.count, b4.busy, b4.expired, b4.zero);
        end
    endtask

    task automatic test_reset_mid_run();
        exp_t e;
        for (int i = 0; i < 10; i++) begin
            b1.enable = 1'b1; b1.load = (i == 0); b1.load_value = 4'd9; b1.reload_mode = 1'b0;
            reset = (i == 4);
            if (i == 0)     sbq.push_back(mk(9, 1'b1, 1'b0));
            else if (i < 4) sbq.push_back(mk(9 - i, 1'b1, 1'b0));
            else            sbq.push_back(mk(0, 1'b0, 1'b0));
            @(posedge clock); #1;
            e = sbq.pop_front();
            checks++;
            if ({b1.count, b1.busy, b1.expired, b1.zero} !== {e.cnt, e.busy, e.exp, e.zero}) begin
                errors++;
                $display("FAIL reset_mid_run cyc%0d: got count=%0d busy=%0b exp=%0b zero=%0b, want %0d/%0b/%0b/%0b",
                         i, b1.count, b1.busy, b1.expired, b1.zero, e.cnt, e.busy, e.exp, e.zero);
            end
        end
        reset = 1'b0;
    endtask

    task automatic test_one_shot();
        exp_t e;
        for (int i = 0; i < 24; i++) begin
            b1.enable = 1'b1; b1.load = (i == 0); b1.load_value = 4'd3; b1.reload_mode = 1'b0;
            if (i < 3)       sbq.push_back(mk(3 - i, 1'b1, 1'b0));
            else if (i == 3) sbq.push_back(mk(0, 1'b0, 1'b1));
            else             sbq.push_back(mk(0, 1'b0, 1'b0));
            @(posedge clock); #1;
            e = sbq.pop_front();
            checks++;
            if ({b1.count, b1.busy, b1.expired, b1.zero} !== {e.cnt, e.busy, e.exp, e.zero}) begin
                errors++;
                $display("FAIL one_shot cyc%0d: got count=%0d busy=%0b exp=%0b zero=%0b, want %0d/%0b/%0b/%0b",
                         i, b1.count, b1.busy, b1.expired, b1.zero, e.cnt, e.busy, e.exp, e.zero);
            end
        end
        b1.load = 1'b0;
    endtask

    task automatic test_enable_gating();
        exp_t e;
        for (int i = 0; i < 23; i++) begin
            b4.load = (i == 0); b4.load_value = 4'd2; b4.reload_mode = 1'b0;
            b4.enable = (i >= 1 && i <= 4) || (i >= 15);
            if (i < 4)       sbq.push_back(mk(2, 1'b1, 1'b0));
            else if (i < 18) sbq.push_back(mk(1, 1'b1, 1'b0));
            else if (i == 18) sbq.push_back(mk(0, 1'b0, 1'b1));
            else             sbq.push_back(mk(0, 1'b0, 1'b0));
            @(posedge clock); #1;
            e = sbq.pop_front();
            checks++;
            if ({b4.count, b4.busy, b4.expired, b4.zero} !== {e.cnt, e.busy, e.exp, e.zero}) begin
                errors++;
                $display("FAIL enable_gating cyc%0d: got count=%0d busy=%0b exp=%0b zero=%0b, want %0d/%0b/%0b/%0b",
                         i, b4.count, b4.busy, b4.expired, b4.zero, e.cnt, e.busy, e.exp, e.zero);
            end
        end
        b4.load = 1'b0; b4.enable = 1'b0;
    endtask

    task automatic test_auto_reload();
        exp_t e;
        int   pulses = 0;
        for (int i = 0; i < 18; i++) begin
            b1.enable = 1'b1; b1.load = (i == 0); b1.load_value = 4'd2;
            b1.reload_mode = (i <= 12);
            if (i == 0)       sbq.push_back(mk(2, 1'b1, 1'b0));
            else if (i <= 12) sbq.push_back((i % 2 == 0) ? mk(2, 1'b1, 1'b1) : mk(1, 1'b1, 1'b0));
            else if (i == 13) sbq.push_back(mk(1, 1'b1, 1'b0));
            else if (i == 14) sbq.push_back(mk(0, 1'b0, 1'b1));
            else              sbq.push_back(mk(0, 1'b0, 1'b0));
            @(posedge clock); #1;
            if (i >= 1 && i <= 12 && b1.expired === 1'b1) pulses++;
            e = sbq.pop_front();
            checks++;
            if ({b1.count, b1.busy, b1.expired, b1.zero} !== {e.cnt, e.busy, e.exp, e.zero}) begin
                errors++;
                $display("FAIL auto_reload cyc%0d: got count=%0d busy=%0b exp=%0b zero=%0b, want %0d/%0b/%0b/%0b",
                         i, b1.count, b1.busy, b1.expired, b1.zero, e.cnt, e.busy, e.exp, e.zero);
            end
        end
        checks++;
        if (pulses != 6) begin
            errors++;
            $display("FAIL auto_reload_pulses: got %0d, want 6", pulses);
        end
        b1.load = 1'b0; b1.reload_mode = 1'b0;
    endtask

    task automatic test_collision();
        exp_t e;
        for (int i = 0; i < 8; i++) begin
            b1.enable = 1'b1; b1.reload_mode = 1'b0;
            b1.load = (i == 0 || i == 1);
            b1.load_value = (i == 0) ? 4'd1 : 4'd5;
            if (i == 0)      sbq.push_back(mk(1, 1'b1, 1'b0));
            else if (i < 6)  sbq.push_back(mk(6 - i, 1'b1, 1'b0));
            else if (i == 6) sbq.push_back(mk(0, 1'b0, 1'b1));
            else             sbq.push_back(mk(0, 1'b0, 1'b0));
            @(posedge clock); #1;
            e = sbq.pop_front();
            checks++;
            if ({b1.count, b1.busy, b1.expired, b1.zero} !== {e.cnt, e.busy, e.exp, e.zero}) begin
                errors++;
                $display("FAIL collision cyc%0d: got count=%0d busy=%0b exp=%0b zero=%0b, want %0d/%0b/%0b/%0b",
                         i, b1.count, b1.busy, b1.expired, b1.zero, e.cnt, e.busy, e.exp, e.zero);
            end
        end
        b1.load = 1'b0;
    endtask

    task automatic test_abort_and_max();
        exp_t e;
        for (int i = 0; i < 25; i++) begin
            b1.enable = 1'b1; b1.reload_mode = 1'b0;
            b1.load = (i == 0 || i == 1 || i == 4);
            b1.load_value = (i == 0) ? 4'd7 : (i == 1) ? 4'd0 : 4'd15;
            if (i == 0)       sbq.push_back(mk(7, 1'b1, 1'b0));
            else if (i < 4)   sbq.push_back(mk(0, 1'b0, 1'b0));
            else if (i < 19)  sbq.push_back(mk(19 - i, 1'b1, 1'b0));
            else if (i == 19) sbq.push_back(mk(0, 1'b0, 1'b1));
            else              sbq.push_back(mk(0, 1'b0, 1'b0));
            @(posedge clock); #1;
            e = sbq.pop_front();
            checks++;
            if ({b1.count, b1.busy, b1.expired, b1.zero} !== {e.cnt, e.busy, e.exp, e.zero}) begin
                errors++;
                $display("FAIL abort_and_max cyc%0d: got count=%0d busy=%0b exp=%0b zero=%0b, want %0d/%0b/%0b/%0b",
                         i, b1.count, b1.busy, b1.expired, b1.zero, e.cnt, e.busy, e.exp, e.zero);
            end
        end
        b1.load = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        b1.enable = 1'b0; b1.load = 1'b0; b1.load_value = 4'd0; b1.reload_mode = 1'b0;
        b4.enable = 1'b0; b4.load = 1'b0; b4.load_value = 4'd0; b4.reload_mode = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        test_reset();
        reset = 1'b0;
        test_reset_mid_run();
        test_one_shot();
        test_enable_gating();
        test_auto_reload();
        test_collision();
        test_abort_and_max();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/down_counter_timer.md
Name: down_counter_timer

Overview:
- Loadable down-counter/timer: the decrementing counterpart of the team's 4-bit enable-gated up-counter.
- Software or an FSM loads a start value. The block counts down on enabled, prescaled ticks and pulses `expired` when it reaches zero.
- It then either stops (one-shot) or reloads (periodic).
- Sits next to the up-counter in the simulation and example hardware set as a timeout and periodic-tick source.

Parameters:
- WIDTH, 4, counter and load-value width in bits.
- PRESCALE, 1, enabled clock cycles per count tick; legal range 1..256.

Ports:
- clock  input  1  design clock; all state changes on posedge.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  active-high count enable; when low, the counter and prescaler freeze.
- load  input  1  one-cycle strobe; captures load_value.
- load_value  input  WIDTH  start and reload value.
- reload_mode  input  1  1 = periodic auto-reload; 0 = one-shot. Sampled on every terminal tick.
- count  output  WIDTH  current counter value.
- busy  output  1  high while in RUN.
- zero  output  1  high when count == 0 (combinational from count).
- expired  output  1  one-cycle registered pulse on terminal tick.

Behaviour:
- Priority per edge: reset > load > tick.
- Reset (reset=1 at posedge):
  - count=0, reload_reg=0, prescale counter=0, state=IDLE.
  - busy=0, expired=0, zero=1.
  - Reset mid-run aborts immediately; no expired pulse.
- States:
  - IDLE (not counting)
  - RUN (counting)
- Load, accepted in any state:
  - count <= load_value, reload_reg <= load_value, prescale counter <= 0.
  - If load_value != 0: state <= RUN.
  - If load_value == 0: state <= IDLE, no expired pulse (load of 0 = abort).
  - Load during RUN restarts the count; any pending terminal tick on that edge is discarded, so expired stays 0.
- Prescaler:
  - In RUN with enable=1, the prescale counter increments.
  - A tick occurs on the cycle it equals PRESCALE-1; it then returns to 0.
  - PRESCALE=1 means every enabled cycle is a tick.
  - enable=0 holds the prescale counter and count unchanged.
  - The prescale counter is held at 0 in IDLE.
- Tick in RUN, count > 1: count <= count-1.
- Tick in RUN, count == 1 (terminal tick): expired <= 1 for exactly one cycle, then:
  - reload_mode=1: count <= reload_reg, stay RUN.
  - reload_mode=0: count <= 0, state <= IDLE.
- Latency: after a load of N at edge k with PRESCALE=P and enable held high, expired is high in the cycle following edge k+N*P.
- Arithmetic and hold rules:
  - count never wraps below 0.
  - No tick is ever applied in IDLE; count holds there.
  - Maximum load is 2^WIDTH-1.
- busy = (state == RUN), registered.
- expired is 0 in every cycle that is not directly after a terminal tick.

Decomposition:
- Shared package (counter_pkg): state encoding constants (ST_IDLE=0, ST_RUN=1) and the default WIDTH constant, shared with the up-counter block.
- One natural sub-module: `prescaler`. It takes clock, reset, clear, enable and produces a tick, with a PRESCALE parameter; the top instantiates it with clear = load | ~busy.
- Top-level FSM and counter stay in down_counter_timer.

Test Plan:
1. Reset mid-run: load 9, run 3 ticks, assert reset 1 cycle -> next cycle count=0, busy=0, zero=1, expired never pulses.
2. One-shot, PRESCALE=1, enable=1, reload_mode=0, load 3:
   - count sequence 3,2,1,0 on successive cycles.
   - expired=1 only in the cycle count becomes 0.
   - busy falls with it; count holds 0 for 20 further cycles.
3. Enable gating, PRESCALE=4, load 2:
   - enable high for 4 cycles -> count=1.
   - enable low for 10 cycles -> count stays 1, no pulse.
   - enable high for 4 cycles -> count=0 with expired pulse.
   - Total 8 enabled cycles.
4. Auto-reload, PRESCALE=1, reload_mode=1, load 2, enable held for 12 cycles:
   - expired pulses every 2nd cycle, 6 pulses total.
   - count alternates 1,2; busy stays 1.
   - Clear reload_mode -> stops at 0 after the next pulse.
5. Collision: PRESCALE=1, load 1, then on the terminal-tick cycle assert load with load_value=5 -> count=5, expired=0, busy=1.
6. Load of 0 while RUN with count=7 -> count=0, busy=0, expired=0. Load 15 (max, WIDTH=4) -> 15 ticks to expire, no wrap past 0.
